brief_kp_scheduler: RTL and testbench
=====================================

# brief_kp_scheduler

Sequences keypoints into the BRIEF descriptor stage. Queues oriented keypoints (coordinate, score, depth, sin, cos) from the orientation stage. Presents the oldest one to BRIEF and holds it stable through BRIEF's 3-stage pipeline once the sliding-window centre reaches it. Drops keypoints the raster scan has already passed, and filters duplicate descriptors on the BRIEF output before forwarding them downstream.

## Interface
Parameters:
- `DEPTH`, 16: keypoint queue entries; power of 2, ≥2.
- `DROP_W`, 16: drop-counter width.

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_frame_start` in 1: one-cycle pulse at start of a frame.
- `i_kp_valid` in 1: upstream keypoint valid.
- `o_kp_ready` in 1-bit out: queue can accept; equals count < DEPTH.
- `i_kp_coor_x`, `i_kp_coor_y` in 10: keypoint position.
- `i_kp_score` in 8, `i_kp_depth` in 10: keypoint score and depth.
- `i_kp_sin`, `i_kp_cos` in signed 12: orientation.
- `i_buf_valid` in 1: window buffer centre advanced this cycle.
- `i_buf_coor_x`, `i_buf_coor_y` in 10: current window centre.
- `i_hit` in 1: BRIEF hit indication.
- `o_coor_x`, `o_coor_y` out 10: head keypoint position to BRIEF.
- `o_score` out 8, `o_depth` out 10: head keypoint score and depth to BRIEF.
- `o_sin`, `o_cos` out signed 12: head keypoint orientation to BRIEF.
- `i_brief_flag` in 1, `i_brief_coor_x`, `i_brief_coor_y` in 10, `i_brief_desc` in 256: BRIEF outputs.
- `o_desc_valid` out 1, `o_desc_coor_x`, `o_desc_coor_y` out 10, `o_desc` out 256: filtered descriptor, one-cycle pulse, no back-pressure.
- `o_drop` out 1: pulse when a stale keypoint is discarded.
- `o_drop_cnt` out DROP_W: saturating drop count for the current frame.
- `o_pending` out clog2(DEPTH)+1: queue occupancy.

## Operation
- **Push:** when `i_kp_valid && o_kp_ready`.
- **Pop:** only by the state machine.
- **Simultaneous push and pop:** allowed.
- **States:**
  - **IDLE** (queue empty): BRIEF-facing outputs are 0. Because a coordinate of 0 never flags in BRIEF, it stays idle.
  - **WAIT:** head is presented on `o_*`.
    - `i_hit` → HOLD1.
    - Else, if `i_buf_valid` and the centre is raster-past the head (buf_y > kp_y, or buf_y == kp_y and buf_x > kp_x): pop and pulse `o_drop`, which increments `o_drop_cnt` (saturating).
    - A hit has priority over the stale check.
  - **HOLD1 → HOLD2:** head held unchanged; `i_hit` is ignored.
  - **HOLD2:** head held; pop at end of cycle. Next state is WAIT if entries remain (counting a same-cycle push), else IDLE.
- **Frame start:** `i_frame_start` flushes the queue, sets the state to IDLE and clears `o_drop_cnt`. A push in the same cycle is accepted into the now-empty queue. An in-flight HOLD is aborted and its descriptor is still filtered normally.
- **Descriptor filter:**
  - `o_desc_valid` = `i_brief_flag` AND (coor ≠ last forwarded coor).
  - Last forwarded coor is cleared to 0 on reset and on frame start.
  - `o_desc*` are registered copies of the BRIEF outputs.
- **Width rules:** coordinate comparisons are unsigned 10-bit. `o_pending` counts 0..DEPTH.

## Timing
- **Reset:** every output is 0, except `o_kp_ready` = 1. The state is IDLE and the queue is empty.
- **Push into an empty queue at cycle T:** head appears on `o_*` at T+1 (registered outputs); state is WAIT at T+1.
- **Hit at cycle T (in WAIT):** outputs stay constant for T, T+1 and T+2. BRIEF samples sin/cos/score at T and coor at T+2. Pop happens at the end of T+2; the next head appears at T+3.
- **Stale drop at cycle T:** `o_drop` = 1 at T+1; the next head appears at T+1.
- **Full queue:** `o_kp_ready` = 0 combinationally. A pop frees a slot for the next cycle, not the same cycle.
- **Descriptor path:** `o_desc_valid` lags `i_brief_flag` by 1 cycle.
- **Reset mid-HOLD:** immediate return to the reset state; no pop is counted.

## Structure
- **Package `brief_sched_pkg`:**
  - `kp_t` packed struct (x 10, y 10, score 8, depth 10, sin s12, cos s12).
  - State enum {IDLE, WAIT, HOLD1, HOLD2}.
  - `COOR_W` = 10, `DESC_W` = 256.
- **Sub-module `kp_fifo`:** parameterised synchronous FIFO of `kp_t` with push, pop, flush, count, full and empty. The scheduler FSM, stale comparator and descriptor filter live in the top module.

## Test plan
- **Single hit:** push (100,50,score 40,depth 7,sin 0,cos 1024) into an empty queue; step the centre to (100,50) with `i_hit` at T → `o_coor` = (100,50) held T..T+2; IDLE at T+3; `o_pending` 1→0.
- **Stale drop:** push (10,5); present centre (11,5) with `i_buf_valid` → `o_drop` pulse, `o_drop_cnt` = 1, queue empty. Then push (20,6) at centre (5,7) → dropped, count 2.
- **Full queue:** push 16 entries → `o_kp_ready` = 0 with `i_kp_valid` held. Hit and finish HOLD2 → ready = 1 next cycle; the 17th push is accepted.
- **Frame start:** with 5 entries pending and drop count 3, pulse `i_frame_start` plus a push of (30,30) → `o_pending` = 1, `o_drop_cnt` = 0, head = (30,30).
- **Duplicate filter:** `i_brief_flag` for (98,50) on two consecutive cycles → exactly one `o_desc_valid`. A later flag for (120,50) → a second `o_desc_valid`.
- **Reset mid-HOLD:** assert `i_rst` in HOLD1 → next cycle all outputs 0, ready = 1, queue empty.

Source files
------------

// File: rtl/brief_sched_pkg.sv
// Shared types for the BRIEF keypoint scheduler: keypoint record, FSM states, widths.
// No logic and no latency; the raster_past helper is purely combinational.
// No flow control lives here.
package brief_sched_pkg;

    localparam int COOR_W = 10;
    localparam int DESC_W = 256;

    typedef struct packed {
        logic [COOR_W-1:0] x;
        logic [COOR_W-1:0] y;
        logic [7:0]        score;
        logic [9:0]        depth;
        logic signed [11:0] sin;
        logic signed [11:0] cos;
    } kp_t;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD1, HOLD2} state_t;

    // True when the scan centre (b) has moved strictly beyond keypoint (k) in raster order.
    function automatic logic raster_past(input logic [COOR_W-1:0] bx, input logic [COOR_W-1:0] by,
                                         input logic [COOR_W-1:0] kx, input logic [COOR_W-1:0] ky);
        return (by > ky) || ((by == ky) && (bx > kx));
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// Synchronous keypoint FIFO with flush; head is readable directly from storage.
// Latency: a push is visible at the head one cycle later; count updates each cycle.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over pop.
module kp_fifo
    import brief_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  kp_t                      i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output kp_t                      o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    kp_t            mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  wr_idx;
    logic           do_push, do_pop;

    assign o_full     = (count_q == CW'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_head_dat = mem_q[rd_ptr_q];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty && !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_idx   = wr_ptr_q;
        if (i_flush) begin
            // A push alongside a flush lands in slot 0 of the emptied queue.
            wr_idx   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = do_push ? AW'(1) : '0;
            count_d  = do_push ? CW'(1) : '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= i_push_dat;
        end
    end

endmodule

// File: rtl/brief_kp_scheduler.sv
// Queues oriented keypoints, presents the head to BRIEF, drops stale ones, de-duplicates descriptors.
// Latency: head visible 1 cycle after push into empty queue; descriptor output lags BRIEF by 1 cycle.
// Backpressure: o_kp_ready deasserts while the queue is full; descriptor output has none.
module brief_kp_scheduler
    import brief_sched_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_frame_start,
    input  logic                     i_kp_valid,
    output logic                     o_kp_ready,
    input  logic [9:0]               i_kp_coor_x,
    input  logic [9:0]               i_kp_coor_y,
    input  logic [7:0]               i_kp_score,
    input  logic [9:0]               i_kp_depth,
    input  logic signed [11:0]       i_kp_sin,
    input  logic signed [11:0]       i_kp_cos,
    input  logic                     i_buf_valid,
    input  logic [9:0]               i_buf_coor_x,
    input  logic [9:0]               i_buf_coor_y,
    input  logic                     i_hit,
    output logic [9:0]               o_coor_x,
    output logic [9:0]               o_coor_y,
    output logic [7:0]               o_score,
    output logic [9:0]               o_depth,
    output logic signed [11:0]       o_sin,
    output logic signed [11:0]       o_cos,
    input  logic                     i_brief_flag,
    input  logic [9:0]               i_brief_coor_x,
    input  logic [9:0]               i_brief_coor_y,
    input  logic [255:0]             i_brief_desc,
    output logic                     o_desc_valid,
    output logic [9:0]               o_desc_coor_x,
    output logic [9:0]               o_desc_coor_y,
    output logic [255:0]             o_desc,
    output logic                     o_drop,
    output logic [DROP_W-1:0]        o_drop_cnt,
    output logic [$clog2(DEPTH):0]   o_pending
);

    localparam int CW = $clog2(DEPTH) + 1;

    kp_t                 push_dat, head, kp_out;
    logic                push, pop, fifo_full, fifo_empty, stale;
    logic [CW-1:0]       count, cnt_after;

    state_t              state_q, state_d;
    logic                drop_q, drop_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [2*COOR_W-1:0] last_q, last_d;
    logic                desc_vld_q, desc_vld_d;
    logic [COOR_W-1:0]   desc_x_q, desc_y_q;
    logic [DESC_W-1:0]   desc_q;
    logic                fwd;

    assign push_dat = '{x: i_kp_coor_x, y: i_kp_coor_y, score: i_kp_score,
                        depth: i_kp_depth, sin: i_kp_sin, cos: i_kp_cos};
    assign o_kp_ready = !fifo_full;
    assign push       = i_kp_valid && o_kp_ready;

    kp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (push),
        .i_push_dat (push_dat),
        .i_pop      (pop),
        .i_flush    (i_frame_start),
        .o_head_dat (head),
        .o_count    (count),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    assign stale = raster_past(i_buf_coor_x, i_buf_coor_y, head.x, head.y);

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            WAIT:    pop = !i_hit && i_buf_valid && stale;
            HOLD2:   pop = 1'b1;
            default: pop = 1'b0;
        endcase
        if (i_frame_start) begin
            pop = 1'b0;
        end

        cnt_after = i_frame_start ? CW'(push) : (count + CW'(push) - CW'(pop));

        case (state_q)
            IDLE:  state_d = (cnt_after != '0) ? WAIT : IDLE;
            WAIT: begin
                if (i_hit) begin
                    state_d = HOLD1;
                end else if (pop) begin
                    drop_d  = 1'b1;
                    if (drop_cnt_q != {DROP_W{1'b1}}) begin
                        drop_cnt_d = drop_cnt_q + DROP_W'(1);
                    end
                    state_d = (cnt_after != '0) ? WAIT : IDLE;
                end
            end
            HOLD1: state_d = HOLD2;
            HOLD2: state_d = (cnt_after != '0) ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase

        // Frame start aborts any hold; the queue refills from the same-cycle push.
        if (i_frame_start) begin
            state_d    = IDLE;
            drop_d     = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_comb begin
        fwd        = i_brief_flag && ({i_brief_coor_x, i_brief_coor_y} != last_q);
        desc_vld_d = fwd;
        last_d     = last_q;
        if (i_frame_start) begin
            last_d = '0;
        end else if (fwd) begin
            last_d = {i_brief_coor_x, i_brief_coor_y};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            last_q     <= '0;
            desc_vld_q <= 1'b0;
            desc_x_q   <= '0;
            desc_y_q   <= '0;
            desc_q     <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            last_q     <= last_d;
            desc_vld_q <= desc_vld_d;
            desc_x_q   <= i_brief_coor_x;
            desc_y_q   <= i_brief_coor_y;
            desc_q     <= i_brief_desc;
        end
    end

    // Zeroed coordinates while idle keep BRIEF from ever flagging.
    assign kp_out = ((state_q == IDLE) || fifo_empty) ? '0 : head;

    assign o_coor_x      = kp_out.x;
    assign o_coor_y      = kp_out.y;
    assign o_score       = kp_out.score;
    assign o_depth       = kp_out.depth;
    assign o_sin         = kp_out.sin;
    assign o_cos         = kp_out.cos;
    assign o_desc_valid  = desc_vld_q;
    assign o_desc_coor_x = desc_x_q;
    assign o_desc_coor_y = desc_y_q;
    assign o_desc        = desc_q;
    assign o_drop        = drop_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_pending     = count;

endmodule

// File: tb/tb_brief_kp_scheduler.sv
// Directed bench for brief_kp_scheduler; descriptor outputs are scored against a queue
// of expected forwards built while BRIEF flags are driven.
module tb_brief_kp_scheduler;

    logic               i_clk = 1'b0;
    logic               i_rst, i_frame_start, i_kp_valid, o_kp_ready;
    logic [9:0]         i_kp_coor_x, i_kp_coor_y, i_kp_depth;
    logic [7:0]         i_kp_score;
    logic signed [11:0] i_kp_sin, i_kp_cos;
    logic               i_buf_valid, i_hit;
    logic [9:0]         i_buf_coor_x, i_buf_coor_y;
    logic [9:0]         o_coor_x, o_coor_y, o_depth;
    logic [7:0]         o_score;
    logic signed [11:0] o_sin, o_cos;
    logic               i_brief_flag;
    logic [9:0]         i_brief_coor_x, i_brief_coor_y;
    logic [255:0]       i_brief_desc;
    logic               o_desc_valid;
    logic [9:0]         o_desc_coor_x, o_desc_coor_y;
    logic [255:0]       o_desc;
    logic               o_drop;
    logic [15:0]        o_drop_cnt;
    logic [4:0]         o_pending;

    typedef struct {
        logic [9:0]   x;
        logic [9:0]   y;
        logic [255:0] d;
    } desc_exp_t;

    desc_exp_t   exp_q[$];
    logic [19:0] model_last = '0;
    int          checks = 0;
    int          failures = 0;
    int          desc_events = 0;

    always #5 i_clk = ~i_clk;

    brief_kp_scheduler #(.DEPTH(16), .DROP_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
        .i_kp_valid(i_kp_valid), .o_kp_ready(o_kp_ready),
        .i_kp_coor_x(i_kp_coor_x), .i_kp_coor_y(i_kp_coor_y),
        .i_kp_score(i_kp_score), .i_kp_depth(i_kp_depth),
        .i_kp_sin(i_kp_sin), .i_kp_cos(i_kp_cos),
        .i_buf_valid(i_buf_valid), .i_buf_coor_x(i_buf_coor_x), .i_buf_coor_y(i_buf_coor_y),
        .i_hit(i_hit),
        .o_coor_x(o_coor_x), .o_coor_y(o_coor_y), .o_score(o_score), .o_depth(o_depth),
        .o_sin(o_sin), .o_cos(o_cos),
        .i_brief_flag(i_brief_flag), .i_brief_coor_x(i_brief_coor_x),
        .i_brief_coor_y(i_brief_coor_y), .i_brief_desc(i_brief_desc),
        .o_desc_valid(o_desc_valid), .o_desc_coor_x(o_desc_coor_x),
        .o_desc_coor_y(o_desc_coor_y), .o_desc(o_desc),
        .o_drop(o_drop), .o_drop_cnt(o_drop_cnt), .o_pending(o_pending)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_kp(input logic [9:0] x, input logic [9:0] y);
        i_kp_valid  = 1'b1;
        i_kp_coor_x = x;
        i_kp_coor_y = y;
        i_kp_score  = x[7:0];
        i_kp_depth  = y;
        i_kp_sin    = 12'sd0;
        i_kp_cos    = 12'sd1024;
    endtask

    task automatic set_buf(input logic [9:0] x, input logic [9:0] y);
        i_buf_valid  = 1'b1;
        i_buf_coor_x = x;
        i_buf_coor_y = y;
    endtask

    task automatic frame_pulse();
        i_frame_start = 1'b1;
        model_last    = '0;
    endtask

    task automatic brief_drive(input logic [9:0] x, input logic [9:0] y);
        desc_exp_t e;
        logic [255:0] d;
        d = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        i_brief_flag   = 1'b1;
        i_brief_coor_x = x;
        i_brief_coor_y = y;
        i_brief_desc   = d;
        if ({x, y} != model_last) begin
            e.x = x; e.y = y; e.d = d;
            exp_q.push_back(e);
            model_last = {x, y};
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_desc_valid) begin
            desc_events++;
            if (exp_q.size() == 0) begin
                chk("desc_unexpected", 256'(o_desc_valid), 256'(0));
            end else begin
                desc_exp_t e;
                e = exp_q.pop_front();
                chk("desc_x", o_desc_coor_x, e.x);
                chk("desc_y", o_desc_coor_y, e.y);
                chk("desc_val", o_desc, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_frame_start = 1'b0; i_kp_valid = 1'b0;
        i_kp_coor_x = '0; i_kp_coor_y = '0; i_kp_score = '0; i_kp_depth = '0;
        i_kp_sin = '0; i_kp_cos = '0;
        i_buf_valid = 1'b0; i_buf_coor_x = '0; i_buf_coor_y = '0; i_hit = 1'b0;
        i_brief_flag = 1'b0; i_brief_coor_x = '0; i_brief_coor_y = '0; i_brief_desc = '0;
        tick(); tick();
        chk("rst_coor_x", o_coor_x, 0);
        chk("rst_ready", o_kp_ready, 1);
        chk("rst_pending", o_pending, 0);
        chk("rst_drop_cnt", o_drop_cnt, 0);
        chk("rst_desc_valid", o_desc_valid, 0);
        i_rst = 1'b0;
        tick();

        // Single hit: head held three cycles, then queue empties.
        set_kp(10'd100, 10'd50);
        i_kp_score = 8'd40; i_kp_depth = 10'd7;
        tick();
        i_kp_valid = 1'b0;
        chk("hit_pending1", o_pending, 1);
        chk("hit_x_T", o_coor_x, 100);
        chk("hit_y_T", o_coor_y, 50);
        chk("hit_score", o_score, 40);
        chk("hit_depth", o_depth, 7);
        chk("hit_sin", o_sin, 0);
        chk("hit_cos", o_cos, 1024);
        set_buf(10'd100, 10'd50);
        i_hit = 1'b1;
        tick();
        i_hit = 1'b0; i_buf_valid = 1'b0;
        chk("hit_x_T1", o_coor_x, 100);
        chk("hit_y_T1", o_coor_y, 50);
        tick();
        chk("hit_x_T2", o_coor_x, 100);
        chk("hit_pending_T2", o_pending, 1);
        tick();
        chk("hit_idle_x_T3", o_coor_x, 0);
        chk("hit_pending_T3", o_pending, 0);
        chk("hit_no_drop", o_drop, 0);

        // Stale drops: x-past on same row, then a later row.
        set_kp(10'd10, 10'd5);
        tick();
        i_kp_valid = 1'b0;
        chk("stale1_head", o_coor_x, 10);
        set_buf(10'd11, 10'd5);
        tick();
        i_buf_valid = 1'b0;
        chk("stale1_drop", o_drop, 1);
        chk("stale1_cnt", o_drop_cnt, 1);
        chk("stale1_pending", o_pending, 0);
        set_kp(10'd20, 10'd6);
        tick();
        i_kp_valid = 1'b0;
        set_buf(10'd5, 10'd7);
        tick();
        i_buf_valid = 1'b0;
        chk("stale2_drop", o_drop, 1);
        chk("stale2_cnt", o_drop_cnt, 2);
        tick();
        chk("stale2_pulse_end", o_drop, 0);

        // Boundaries: equal centre and earlier row are not stale.
        set_kp(10'd50, 10'd20);
        tick();
        i_kp_valid = 1'b0;
        set_buf(10'd50, 10'd20);
        tick();
        chk("equal_not_stale", o_pending, 1);
        chk("equal_no_drop", o_drop, 0);
        set_buf(10'd60, 10'd19);
        tick();
        chk("prev_row_not_stale", o_pending, 1);
        set_buf(10'd51, 10'd20);
        tick();
        i_buf_valid = 1'b0;
        chk("stale3_drop", o_drop, 1);
        chk("stale3_cnt", o_drop_cnt, 3);
        chk("stale3_pending", o_pending, 0);

        // Frame start with 5 pending and drop count 3, plus a same-cycle push.
        for (int i = 0; i < 5; i++) begin
            set_kp(10'(400 + i), 10'd200);
            tick();
        end
        chk("fs_pre_pending", o_pending, 5);
        set_kp(10'd30, 10'd30);
        frame_pulse();
        tick();
        i_frame_start = 1'b0; i_kp_valid = 1'b0;
        chk("fs_pending", o_pending, 1);
        chk("fs_drop_cnt", o_drop_cnt, 0);
        tick();
        chk("fs_head_x", o_coor_x, 30);
        chk("fs_head_y", o_coor_y, 30);
        frame_pulse();
        tick();
        i_frame_start = 1'b0;
        chk("fs_flush_pending", o_pending, 0);
        chk("fs_flush_idle", o_coor_x, 0);

        // Full queue: ready drops, frees only after the HOLD2 pop.
        for (int i = 0; i < 16; i++) begin
            set_kp(10'(200 + i), 10'd100);
            tick();
        end
        set_kp(10'd300, 10'd100);
        chk("full_pending", o_pending, 16);
        chk("full_ready", o_kp_ready, 0);
        tick();
        chk("full_blocked", o_pending, 16);
        i_hit = 1'b1;
        tick();
        i_hit = 1'b0;
        chk("full_hold1_ready", o_kp_ready, 0);
        chk("full_head", o_coor_x, 200);
        tick();
        chk("full_hold2_ready", o_kp_ready, 0);
        chk("full_hold2_pending", o_pending, 16);
        tick();
        chk("full_after_pop_ready", o_kp_ready, 1);
        chk("full_after_pop_pending", o_pending, 15);
        chk("full_next_head", o_coor_x, 201);
        tick();
        i_kp_valid = 1'b0;
        chk("full_17th_pending", o_pending, 16);
        chk("full_17th_ready", o_kp_ready, 0);
        frame_pulse();
        tick();
        i_frame_start = 1'b0;

        // Duplicate filter.
        brief_drive(10'd98, 10'd50);
        tick();
        chk("dup_first_valid", o_desc_valid, 1);
        chk("dup_first_x", o_desc_coor_x, 98);
        brief_drive(10'd98, 10'd50);
        tick();
        i_brief_flag = 1'b0;
        chk("dup_second_suppressed", o_desc_valid, 0);
        tick();
        brief_drive(10'd120, 10'd50);
        tick();
        chk("new_coor_valid", o_desc_valid, 1);
        brief_drive(10'd98, 10'd50);
        tick();
        i_brief_flag = 1'b0;
        chk("return_coor_valid", o_desc_valid, 1);
        tick();
        chk("desc_pulse_end", o_desc_valid, 0);

        // Reset in HOLD1.
        set_kp(10'd70, 10'd60);
        tick();
        i_kp_valid = 1'b0;
        i_hit = 1'b1;
        tick();
        i_hit = 1'b0;
        chk("rh_hold1_x", o_coor_x, 70);
        i_rst = 1'b1;
        tick();
        chk("rh_coor_x", o_coor_x, 0);
        chk("rh_coor_y", o_coor_y, 0);
        chk("rh_cos", o_cos, 0);
        chk("rh_ready", o_kp_ready, 1);
        chk("rh_pending", o_pending, 0);
        chk("rh_desc_coor", o_desc_coor_x, 0);
        i_rst = 1'b0;
        model_last = '0;
        tick();
        chk("rh_stays_idle", o_coor_x, 0);
        tick();

        chk("desc_queue_drained", exp_q.size(), 0);
        chk("desc_event_count", desc_events, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
